multiplexor_n_a_1: RTL and testbench

MULTIPLEXOR_N_A_1 -- requirements
Module: multiplexor_n_a_1

---
 rtl/multiplexor_n_a_1.sv | 116 +++++++++++
 tb/tb_multiplexor_n_a_1.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_n_a_1.sv
// Registered N-to-1 multiplexer. It has a manual channel select and an automatic
// scan mode that dwells PERIODO enabled cycles on each channel.
module multiplexor_n_a_1 #(
    parameter int ANCHO   = 8,
    parameter int CANALES = 4,
    parameter int PERIODO = 4,
    parameter int SEL_W   = $clog2(CANALES)
) (
    input  logic                       Reloj,
    input  logic                       Reset,
    input  logic [CANALES*ANCHO-1:0]   Entradas,
    input  logic [SEL_W-1:0]           Selector,
    input  logic                       Modo,
    input  logic                       Habilitar,
    output logic [ANCHO-1:0]           Salida,
    output logic [SEL_W-1:0]           Canal,
    output logic                       Valida,
    output logic                       Error
);

    localparam int PER_W = $clog2(PERIODO + 1);

    typedef enum logic {
        MANUAL  = 1'b0,
        BARRIDO = 1'b1
    } modo_e;

    modo_e              modo;
    logic [ANCHO-1:0]   salida_d, salida_q;
    logic [SEL_W-1:0]   canal_d, canal_q;
    logic               valida_d, valida_q;
    logic               error_d, error_q;
    logic [SEL_W-1:0]   idx_d, idx_q;
    logic [PER_W-1:0]   per_d, per_q;

    // Linear decode so a non-power-of-two CANALES never indexes past the bus.
    function automatic logic [ANCHO-1:0] canal_dato(
        input logic [CANALES*ANCHO-1:0] ent,
        input logic [SEL_W-1:0]         idx
    );
        logic [ANCHO-1:0] r;
        r = '0;
        for (int i = 0; i < CANALES; i++) begin
            if (int'(idx) == i) r = ent[i*ANCHO +: ANCHO];
        end
        return r;
    endfunction

    assign modo = modo_e'(Modo);

    always_comb begin
        salida_d = salida_q;
        canal_d  = canal_q;
        error_d  = error_q;
        valida_d = 1'b0;
        idx_d    = idx_q;
        per_d    = per_q;
        case (modo)
            MANUAL: begin
                // Counters are cleared while manual, enabled or not, so a scan always starts fresh.
                idx_d = '0;
                per_d = '0;
                if (Habilitar) begin
                    valida_d = 1'b1;
                    canal_d  = Selector;
                    if (int'(Selector) < CANALES) begin
                        salida_d = canal_dato(Entradas, Selector);
                        error_d  = 1'b0;
                    end else begin
                        salida_d = '0;
                        error_d  = 1'b1;
                    end
                end
            end
            BARRIDO: begin
                if (Habilitar) begin
                    valida_d = 1'b1;
                    salida_d = canal_dato(Entradas, idx_q);
                    canal_d  = idx_q;
                    error_d  = 1'b0;
                    if (int'(per_q) == PERIODO - 1) begin
                        per_d = '0;
                        idx_d = (int'(idx_q) == CANALES - 1) ? '0 : idx_q + 1'b1;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            salida_q <= '0;
            canal_q  <= '0;
            valida_q <= 1'b0;
            error_q  <= 1'b0;
            idx_q    <= '0;
            per_q    <= '0;
        end else begin
            salida_q <= salida_d;
            canal_q  <= canal_d;
            valida_q <= valida_d;
            error_q  <= error_d;
            idx_q    <= idx_d;
            per_q    <= per_d;
        end
    end

    assign Salida = salida_q;
    assign Canal  = canal_q;
    assign Valida = valida_q;
    assign Error  = error_q;

endmodule

// File: tb/tb_multiplexor_n_a_1.sv
// Scoreboard bench for multiplexor_n_a_1 with 3 channels of 8 bits and a dwell of 2.
module tb_multiplexor_n_a_1;

    localparam int ANCHO   = 8;
    localparam int CANALES = 3;
    localparam int PERIODO = 2;
    localparam int SEL_W   = $clog2(CANALES);

    logic                     Reloj = 1'b0;
    logic                     Reset = 1'b0;
    logic [CANALES*ANCHO-1:0] Entradas = {8'hC2, 8'hB1, 8'hA0};
    logic [SEL_W-1:0]         Selector = '0;
    logic                     Modo = 1'b0;
    logic                     Habilitar = 1'b0;
    logic [ANCHO-1:0]         Salida;
    logic [SEL_W-1:0]         Canal;
    logic                     Valida;
    logic                     Error;

    typedef struct packed {
        logic [ANCHO-1:0] salida;
        logic [SEL_W-1:0] canal;
        logic             valida;
        logic             error;
    } out_t;

    out_t sb[$];
    out_t m_out = '0;
    int   m_idx = 0;
    int   m_per = 0;
    int   errors = 0;
    int   checks = 0;

    multiplexor_n_a_1 #(
        .ANCHO(ANCHO), .CANALES(CANALES), .PERIODO(PERIODO), .SEL_W(SEL_W)
    ) dut (
        .Reloj(Reloj), .Reset(Reset), .Entradas(Entradas), .Selector(Selector),
        .Modo(Modo), .Habilitar(Habilitar), .Salida(Salida), .Canal(Canal),
        .Valida(Valida), .Error(Error)
    );

    always #5 Reloj = ~Reloj;

    function automatic logic [ANCHO-1:0] ch(input int i);
        return Entradas[i*ANCHO +: ANCHO];
    endfunction

    // Advance the reference model with the current inputs, queue its prediction, then clock.
    task automatic drive_edge();
        if (Reset) begin
            m_out = '0;
            m_idx = 0;
            m_per = 0;
        end else if (!Modo) begin
            m_idx = 0;
            m_per = 0;
            if (Habilitar) begin
                m_out.canal  = Selector;
                m_out.valida = 1'b1;
                m_out.error  = (int'(Selector) >= CANALES);
                m_out.salida = m_out.error ? 8'h00 : ch(int'(Selector));
            end else begin
                m_out.valida = 1'b0;
            end
        end else if (Habilitar) begin
            m_out.salida = ch(m_idx);
            m_out.canal  = SEL_W'(m_idx);
            m_out.valida = 1'b1;
            m_out.error  = 1'b0;
            m_per = (m_per + 1) % PERIODO;
            if (m_per == 0) m_idx = (m_idx + 1) % CANALES;
        end else begin
            m_out.valida = 1'b0;
        end
        sb.push_back(m_out);
        @(posedge Reloj);
        #1;
    endtask

    function automatic out_t observed();
        return '{salida: Salida, canal: Canal, valida: Valida, error: Error};
    endfunction

    task automatic test_reset();
        out_t exp, obs;
        Reset = 1'b1; Habilitar = 1'b1; Modo = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_edge();
            exp = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== exp || obs !== out_t'(0)) begin
                errors++;
                $display("FAIL reset[%0d]: got %h, wanted %h", k, obs, out_t'(0));
            end
        end
        Reset = 1'b0;
    endtask

    task automatic test_manual();
        out_t exp, obs;
        logic [SEL_W-1:0] sels [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
        out_t lit [4] = '{'{8'hB1, 2'd1, 1'b1, 1'b0}, '{8'h00, 2'd3, 1'b1, 1'b1},
                          '{8'hA0, 2'd0, 1'b1, 1'b0}, '{8'hC2, 2'd2, 1'b1, 1'b0}};
        Modo = 1'b0; Habilitar = 1'b1;
        for (int k = 0; k < 4; k++) begin
            Selector = sels[k];
            drive_edge();
            exp = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== exp || obs !== lit[k]) begin
                errors++;
                $display("FAIL manual sel=%0d: got %h, wanted %h", sels[k], obs, lit[k]);
            end
        end
        // Data change on the selected channel shows up one edge later.
        Entradas[2*ANCHO +: ANCHO] = 8'h5A;
        drive_edge();
        exp = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== exp || obs.salida !== 8'h5A) begin
            errors++;
            $display("FAIL manual_data_change: got %h, wanted %h", obs, exp);
        end
        Entradas[2*ANCHO +: ANCHO] = 8'hC2;
    endtask

    task automatic test_scan_wrap();
        out_t exp, obs;
        logic [SEL_W-1:0] canales [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        logic [ANCHO-1:0] datos [8] = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hA0, 8'hA0};
        Modo = 1'b1; Habilitar = 1'b1; Selector = 2'd3;
        for (int k = 0; k < 8; k++) begin
            drive_edge();
            exp = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== exp || obs !== out_t'({datos[k], canales[k], 1'b1, 1'b0})) begin
                errors++;
                $display("FAIL scan[%0d]: got %h, wanted canal %0d data %h", k, obs, canales[k], datos[k]);
            end
        end
    endtask

    task automatic test_enable_hold();
        out_t exp, obs;
        logic [SEL_W-1:0] canales [6] = '{1, 1, 1, 1, 1, 2};
        logic [ANCHO-1:0] datos [6] = '{8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hC2};
        logic             vld [6] = '{1, 0, 0, 0, 1, 1};
        for (int k = 0; k < 6; k++) begin
            Habilitar = vld[k];
            drive_edge();
            exp = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== exp || obs !== out_t'({datos[k], canales[k], vld[k], 1'b0})) begin
                errors++;
                $display("FAIL enable_hold[%0d]: got %h, wanted canal %0d data %h valida %0d",
                         k, obs, canales[k], datos[k], vld[k]);
            end
        end
        Habilitar = 1'b1;
    endtask

    task automatic test_mode_switch();
        out_t exp, obs;
        logic [SEL_W-1:0] canales [4] = '{0, 0, 0, 1};
        Modo = 1'b0; Selector = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) Modo = 1'b1;
            drive_edge();
            exp = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== exp || obs.canal !== canales[k] || obs.salida !== ch(int'(canales[k]))) begin
                errors++;
                $display("FAIL mode_switch[%0d]: got %h, wanted canal %0d", k, obs, canales[k]);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        out_t exp, obs;
        logic [SEL_W-1:0] canales [6] = '{1, 2, 0, 0, 0, 1};
        logic             vld [6] = '{1, 1, 0, 1, 1, 1};
        for (int k = 0; k < 6; k++) begin
            Reset = (k == 2);
            drive_edge();
            exp = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== exp || obs.canal !== canales[k] || obs.valida !== vld[k]) begin
                errors++;
                $display("FAIL reset_mid_scan[%0d]: got %h, wanted canal %0d valida %0d",
                         k, obs, canales[k], vld[k]);
            end
        end
        Reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_t exp, obs;
        for (int k = 0; k < 60; k++) begin
            Entradas  = {CANALES{8'h00}} | {$urandom, $urandom};
            Selector  = SEL_W'($urandom_range(0, 3));
            Modo      = ($urandom_range(0, 3) != 0);
            Habilitar = ($urandom_range(0, 4) != 0);
            Reset     = ($urandom_range(0, 19) == 0);
            drive_edge();
            exp = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h, wanted %h", k, obs, exp);
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        @(posedge Reloj);
        #1;
        test_reset();
        test_manual();
        test_scan_wrap();
        test_enable_hold();
        test_mode_switch();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
